// File: rtl/uart_tx_serializer.sv
// Start / 8 data bits / stop serializer for the processor PIO byte port, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop bits.
module uart_tx_serializer #(
  parameter int CLK_DIV     = 326,
  parameter int BIT_SAMPLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       transmit,
  input  logic [7:0] data_in,
  output logic       tx_serial,
  output logic [3:0] bics,
  output logic       busy,
  output logic       done
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BSC_W = $clog2(BIT_SAMPLES);
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);
  localparam logic [BSC_W-1:0] BSC_MAX  = BSC_W'(BIT_SAMPLES - 1);
  localparam logic [BSC_W-1:0] BSC_ONE  = BSC_W'(1);
  localparam logic [BSC_W-1:0] BSC_ZERO = BSC_W'(0);
`ifdef UART_TX_PARITY_EN
  localparam logic [3:0] LAST_BIT = 4'd10;
`else
  localparam logic [3:0] LAST_BIT = 4'd9;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOADED = 2'd1,
    SEND   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [BSC_W-1:0] bsc_q, bsc_d;
  logic [3:0]       bics_q, bics_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tick;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign tick      = (div_q == DIV_MAX);
  assign tx_serial = tx_q;
  assign bics      = bics_q;
  assign busy      = busy_q;
  assign done      = done_q;

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      shift_q  <= 8'd0;
      div_q    <= DIV_ZERO;
      bsc_q    <= BSC_ZERO;
      bics_q   <= 4'd0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      div_q    <= div_d;
      bsc_q    <= bsc_d;
      bics_q   <= bics_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead so they leave registered
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    div_d    = div_q;
    bsc_d    = bsc_q;
    bics_d   = bics_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        bics_d = 4'd0;
        // transmit is deliberately not looked at here: a byte must be latched first
        if (load) begin
          shift_d  = data_in;
`ifdef UART_TX_PARITY_EN
          parity_d = ^data_in;
`endif
          busy_d   = 1'b1;
          state_d  = LOADED;
        end else begin
          busy_d   = 1'b0;
        end
      end
      LOADED: begin
        tx_d = 1'b1;
        if (load) begin
          shift_d  = data_in;
`ifdef UART_TX_PARITY_EN
          parity_d = ^data_in;
`endif
        end else begin
          shift_d  = shift_q;
        end
        if (transmit) begin
          state_d = SEND;
          div_d   = DIV_ZERO;
          bsc_d   = BSC_ZERO;
          bics_d  = 4'd0;
          tx_d    = 1'b0;
        end else begin
          state_d = LOADED;
        end
      end
      SEND: begin
        if (!tick) begin
          div_d = div_q + DIV_ONE;
        end else begin
          div_d = DIV_ZERO;
          if (bsc_q != BSC_MAX) begin
            bsc_d = bsc_q + BSC_ONE;
          end else begin
            bsc_d = BSC_ZERO;
            if (bics_q == LAST_BIT) begin
              state_d = IDLE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
              bics_d  = 4'd0;
              tx_d    = 1'b1;
            end else begin
              bics_d = bics_q + 4'd1;
              // bics_q 0..7 means the next bit on the line is a data bit
              if (bics_q < 4'd8) begin
                tx_d    = shift_q[0];
                shift_d = {1'b0, shift_q[7:1]};
              end
`ifdef UART_TX_PARITY_EN
              else if (bics_q == 4'd8) begin
                tx_d = parity_q;
              end
`endif
              else begin
                tx_d = 1'b1;
              end
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        bics_d  = 4'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: two instances (CLK_DIV=2/BIT_SAMPLES=4 and 1/2),
// expected frames pushed at stimulus time and checked by per-instance monitors on done.
module tb_uart_tx_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] load_s;
  logic [1:0] transmit_s;
  logic [1:0] tx_s;
  logic [1:0] busy_s;
  logic [1:0] done_s;
  logic [7:0] data_s [2];
  logic [3:0] bics_s [2];

  int cmp_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    int         inst;
    logic [10:0] frame;
  } exp_t;
  exp_t exp_q[$];

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  always #5 clk = ~clk;

  uart_tx_serializer #(.CLK_DIV(2), .BIT_SAMPLES(4)) dut_a (
    .clk(clk), .reset(rst), .load(load_s[0]), .transmit(transmit_s[0]),
    .data_in(data_s[0]), .tx_serial(tx_s[0]), .bics(bics_s[0]),
    .busy(busy_s[0]), .done(done_s[0])
  );

  uart_tx_serializer #(.CLK_DIV(1), .BIT_SAMPLES(2)) dut_b (
    .clk(clk), .reset(rst), .load(load_s[1]), .transmit(transmit_s[1]),
    .data_in(data_s[1]), .tx_serial(tx_s[1]), .bics(bics_s[1]),
    .busy(busy_s[1]), .done(done_s[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Frames are given bit 0 = start bit; the parity variant is used when the feature is built in
  task automatic push_exp(input int g, input logic [10:0] f_np, input logic [10:0] f_p);
    exp_t e;
    e.inst = g;
`ifdef UART_TX_PARITY_EN
    e.frame = f_p;
`else
    e.frame = f_np;
`endif
    exp_q.push_back(e);
  endtask

  task automatic idle_window(input int g, input int n, input string nm);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tx_s[g] !== 1'b1 || bics_s[g] !== 4'd0 || busy_s[g] !== 1'b0 || done_s[g] !== 1'b0)
        bad++;
    end
    chk(nm, bad, 0);
  endtask

  task automatic start_frame(input int g, input logic [7:0] d);
    @(posedge clk); #1;
    load_s[g] = 1'b1;
    data_s[g] = d;
    @(posedge clk); #1;
    load_s[g] = 1'b0;
    @(negedge clk);
    chk("busy_after_load", busy_s[g], 1);
    @(posedge clk); #1;
    transmit_s[g] = 1'b1;
  endtask

  task automatic wait_done(input int g, input int limit, input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (done_s[g] === 1'b1) seen = 1'b1;
    end
    chk(nm, seen, 1);
  endtask

  task automatic wait_bics(input int g, input logic [3:0] val, input int limit, input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (bics_s[g] === val) seen = 1'b1;
    end
    chk(nm, seen, 1);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_mon
    localparam int SPB = (g == 0) ? 8 : 2;
    initial begin
      logic       cap_tx [$];
      logic [3:0] cap_bics [$];
      bit         capturing;
      exp_t       e;
      int         bad_tx, bad_bics, first;
      capturing = 1'b0;
      forever begin
        @(negedge clk);
        if (rst === 1'b1) begin
          capturing = 1'b0;
          cap_tx.delete();
          cap_bics.delete();
        end else if (done_s[g] === 1'b1) begin
          cmp_cnt++;
          if (exp_q.size() == 0 || exp_q[0].inst != g) begin
            err_cnt++;
            $display("FAIL unexpected_done[%0d]: done=1 with no frame expected", g);
          end else begin
            e = exp_q.pop_front();
            if (cap_tx.size() != NB * SPB) begin
              err_cnt++;
              $display("FAIL frame_len[%0d]: got %0d cycles expected %0d", g, cap_tx.size(), NB * SPB);
            end
            bad_tx = 0; bad_bics = 0; first = -1;
            for (int i = 0; i < cap_tx.size() && i < NB * SPB; i++) begin
              if (cap_tx[i] !== e.frame[i / SPB]) begin
                bad_tx++;
                if (first < 0) first = i;
              end
              if (cap_bics[i] !== 4'(i / SPB)) bad_bics++;
            end
            chk("frame_bits", bad_tx, 0);
            if (bad_tx != 0)
              $display("  inst %0d frame %b first bad cycle %0d", g, e.frame, first);
            chk("frame_bics", bad_bics, 0);
            chk("busy_at_done", busy_s[g], 0);
            chk("tx_at_done", tx_s[g], 1);
          end
          capturing = 1'b0;
          cap_tx.delete();
          cap_bics.delete();
        end else begin
          if (!capturing && busy_s[g] === 1'b1 && tx_s[g] === 1'b0) capturing = 1'b1;
          if (capturing) begin
            cap_tx.push_back(tx_s[g]);
            cap_bics.push_back(bics_s[g]);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    load_s     = 2'b00;
    transmit_s = 2'b00;
    data_s[0]  = 8'h00;
    data_s[1]  = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values, then a quiet idle line
    @(negedge clk);
    chk("reset_tx", tx_s[0], 1);
    chk("reset_bics", bics_s[0], 0);
    idle_window(0, 50, "idle_a");
    idle_window(1, 50, "idle_b");

    // 8'hA5, transmit held across frame end
    push_exp(0, 11'b01101001010, 11'b10101001010);
    start_frame(0, 8'hA5);
    wait_done(0, 200, "done_a5");
    idle_window(0, 40, "no_restart");
    @(posedge clk); #1 transmit_s[0] = 1'b0;

    // Mid-frame load of 8'h00 and transmit drop must not disturb the frame
    push_exp(0, 11'b01101001010, 11'b10101001010);
    start_frame(0, 8'hA5);
    wait_bics(0, 4'd3, 200, "reach_bics3");
    @(posedge clk); #1;
    load_s[0] = 1'b1; data_s[0] = 8'h00; transmit_s[0] = 1'b0;
    @(posedge clk); #1 load_s[0] = 1'b0;
    wait_done(0, 200, "done_midload");
    idle_window(0, 40, "no_second_frame");

    // Reset during bics=5: no done pulse, then a clean 8'h3C frame
    start_frame(0, 8'hA5);
    wait_bics(0, 4'd5, 200, "reach_bics5");
    @(posedge clk); #1;
    rst = 1'b1; transmit_s[0] = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_tx", tx_s[0], 1);
    chk("rst_mid_bics", bics_s[0], 0);
    chk("rst_mid_busy", busy_s[0], 0);
    chk("rst_mid_done", done_s[0], 0);
    idle_window(0, 20, "after_reset");
    push_exp(0, 11'b01001111000, 11'b10001111000);
    start_frame(0, 8'h3C);
    wait_done(0, 200, "done_3c");
    @(posedge clk); #1 transmit_s[0] = 1'b0;

    // load and transmit together in IDLE: only the load takes effect
    @(posedge clk); #1;
    load_s[1] = 1'b1; transmit_s[1] = 1'b1; data_s[1] = 8'hFF;
    @(posedge clk); #1;
    load_s[1] = 1'b0; transmit_s[1] = 1'b0;
    begin
      int bad = 0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        if (tx_s[1] !== 1'b1 || busy_s[1] !== 1'b1) bad++;
      end
      chk("idle_load_tx_ignored", bad, 0);
    end

    // CLK_DIV=1, BIT_SAMPLES=2: 8'hFF frame of 2-cycle bits
    push_exp(1, 11'b01111111110, 11'b10111111110);
    @(posedge clk); #1 transmit_s[1] = 1'b1;
    wait_done(1, 100, "done_ff");
    @(posedge clk); #1 transmit_s[1] = 1'b0;

    // Parity sensitive patterns: odd (8'h07) and even (8'h03) weight
    push_exp(1, 11'b01000001110, 11'b11000001110);
    start_frame(1, 8'h07);
    wait_done(1, 100, "done_07");
    @(posedge clk); #1 transmit_s[1] = 1'b0;
    push_exp(1, 11'b01000000110, 11'b10000000110);
    start_frame(1, 8'h03);
    wait_done(1, 100, "done_03");
    @(posedge clk); #1 transmit_s[1] = 1'b0;

    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
